// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the fetch/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W   = 61;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  // One memory access as driven onto the shared port
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rsp_slot.sv
// Single-entry response slot for one requester: tracks the outstanding
// access and holds its response until the requester accepts it.
module rsp_slot
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              grant_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              rsp_ready_i,
  output logic              eligible_c_o,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_c_o
);

  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              fresh_q;
  logic              fresh_we_q;
  logic              drain;
  logic [DATA_W-1:0] fresh_data;

  assign drain        = valid_q & rsp_ready_i;
  assign eligible_c_o = ~busy_q | drain;

  // Memory read data arrives the cycle after issue; stores return zero
  assign fresh_data   = fresh_we_q ? '0 : mem_rdata_i;

  assign rsp_valid_o  = valid_q;
  assign rsp_data_c_o = fresh_q ? fresh_data : data_q;

  // Drain first, then a same-cycle grant re-arms the slot
  always_comb begin
    busy_d  = busy_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (drain) begin
      busy_d  = 1'b0;
      valid_d = 1'b0;
    end
    if (grant_i) begin
      busy_d  = 1'b1;
      valid_d = 1'b1;
    end
    if (fresh_q) begin
      data_d = fresh_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      fresh_q    <= 1'b0;
      fresh_we_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      fresh_q    <= grant_i;
      fresh_we_q <= grant_i & we_i;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Data-priority arbiter sharing one memory port between instruction fetch
// and load/store, with a bounded wait for fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_rsp_valid,
  input  logic              d_rsp_ready,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic                if_elig, d_elig;
  logic                if_cand, d_cand;
  logic                if_gnt, d_gnt;
  req_id_e             winner;
  logic [STARVE_W-1:0] starve_q, starve_d;
  mem_req_t            if_req, d_req, mem_req;

  // Arbitration and starvation counter; nothing is granted while in reset
  always_comb begin
    if_cand  = rst_n & if_req_valid & if_elig;
    d_cand   = rst_n & d_req_valid & d_elig;
    winner   = REQ_D;
    if (if_cand && (!d_cand || starve_q == LIMIT)) begin
      winner = REQ_IF;
    end
    if_gnt   = if_cand & (winner == REQ_IF);
    d_gnt    = d_cand & (winner == REQ_D);
    starve_d = starve_q;
    if (!if_cand || if_gnt) begin
      starve_d = '0;
    end else if (d_gnt && starve_q != LIMIT) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  // Memory port mux; fetch never writes
  always_comb begin
    if_req  = '{we: 1'b0, addr: if_req_addr, wdata: '0};
    d_req   = '{we: d_req_we, addr: d_req_addr, wdata: d_req_wdata};
    mem_req = '0;
    if (d_gnt) begin
      mem_req = d_req;
    end else if (if_gnt) begin
      mem_req = if_req;
    end
  end

  assign if_req_ready = if_gnt;
  assign d_req_ready  = d_gnt;
  assign mem_en       = if_gnt | d_gnt;
  assign mem_we       = mem_req.we;
  assign mem_addr     = mem_req.addr;
  assign mem_wdata    = mem_req.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  rsp_slot u_if_slot (
    .clk          (clk),
    .rst_n        (rst_n),
    .grant_i      (if_gnt),
    .we_i         (1'b0),
    .mem_rdata_i  (mem_rdata),
    .rsp_ready_i  (if_rsp_ready),
    .eligible_c_o (if_elig),
    .rsp_valid_o  (if_rsp_valid),
    .rsp_data_c_o (if_rsp_data)
  );

  rsp_slot u_d_slot (
    .clk          (clk),
    .rst_n        (rst_n),
    .grant_i      (d_gnt),
    .we_i         (d_req_we),
    .mem_rdata_i  (mem_rdata),
    .rsp_ready_i  (d_rsp_ready),
    .eligible_c_o (d_elig),
    .rsp_valid_o  (d_rsp_valid),
    .rsp_data_c_o (d_rsp_data)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [60:0] if_req_addr;
  logic        if_rsp_valid;
  logic        if_rsp_ready;
  logic [63:0] if_rsp_data;
  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_req_we;
  logic [60:0] d_req_addr;
  logic [63:0] d_req_wdata;
  logic        d_rsp_valid;
  logic        d_rsp_ready;
  logic [63:0] d_rsp_data;
  logic        mem_en;
  logic        mem_we;
  logic [60:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  int total;
  int bad;

  logic [63:0]  model [0:255];
  logic [255:0] wr_v;

  bit pat_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_ready (if_rsp_ready),
    .if_rsp_data  (if_rsp_data),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_req_we     (d_req_we),
    .d_req_addr   (d_req_addr),
    .d_req_wdata  (d_req_wdata),
    .d_rsp_valid  (d_rsp_valid),
    .d_rsp_ready  (d_rsp_ready),
    .d_rsp_data   (d_rsp_data),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Background contents for never-written addresses
  function automatic logic [63:0] init_word(input logic [60:0] a);
    if (a == 61'h10) return 64'hDEAD_BEEF_0011_2233;
    return {a, 3'b000} ^ 64'hA5A5_0000_0000_5A5A;
  endfunction

  function automatic logic [63:0] rd_word(input logic [60:0] a);
    return wr_v[a[7:0]] ? model[a[7:0]] : init_word(a);
  endfunction

  // Synchronous memory: read data appears the cycle after issue
  always @(posedge clk) begin
    if (!rst_n) begin
      wr_v      <= '0;
      mem_rdata <= 64'h0;
    end else if (mem_en) begin
      if (mem_we) begin
        model[mem_addr[7:0]] <= mem_wdata;
        wr_v[mem_addr[7:0]]  <= 1'b1;
      end else begin
        mem_rdata <= rd_word(mem_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    if_req_valid = 1'b1;
    if_req_addr  = 61'h7;
    if_rsp_ready = 1'b1;
    d_req_valid  = 1'b1;
    d_req_we     = 1'b0;
    d_req_addr   = 61'h8;
    d_req_wdata  = 64'h0;
    d_rsp_ready  = 1'b1;

    // Reset with both requesters asking
    repeat (2) cyc();
    chk("rst_if_ready", 64'(if_req_ready), 64'h0);
    chk("rst_d_ready",  64'(d_req_ready),  64'h0);
    chk("rst_mem_en",   64'(mem_en),       64'h0);
    chk("rst_mem_we",   64'(mem_we),       64'h0);
    chk("rst_mem_addr", 64'(mem_addr),     64'h0);
    chk("rst_if_valid", 64'(if_rsp_valid), 64'h0);
    chk("rst_d_valid",  64'(d_rsp_valid),  64'h0);
    chk("rst_d_data",   d_rsp_data,        64'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_d_first",  64'(d_req_ready),  64'h1);
    chk("rel_if_wait",  64'(if_req_ready), 64'h0);
    chk("rel_mem_addr", 64'(mem_addr),     64'h8);
    cyc();
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    cyc();
    cyc();

    // Fetch-only read
    if_req_valid = 1'b1;
    if_req_addr  = 61'h10;
    #1;
    chk("f_if_ready", 64'(if_req_ready), 64'h1);
    chk("f_d_ready",  64'(d_req_ready),  64'h0);
    chk("f_mem_en",   64'(mem_en),       64'h1);
    chk("f_mem_we",   64'(mem_we),       64'h0);
    chk("f_mem_addr", 64'(mem_addr),     64'h10);
    chk("f_wdata",    mem_wdata,         64'h0);
    cyc();
    if_req_valid = 1'b0;
    #1;
    chk("f_rsp_valid", 64'(if_rsp_valid), 64'h1);
    chk("f_rsp_data",  if_rsp_data,       64'hDEAD_BEEF_0011_2233);
    cyc();
    chk("f_rsp_drop",  64'(if_rsp_valid), 64'h0);

    // Contention: D,D,D,D,I repeating
    if_req_addr  = 61'h30;
    d_req_addr   = 61'h40;
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("cont_d_gnt",  64'(d_req_ready),  64'(pat_d[i]));
      chk("cont_if_gnt", 64'(if_req_ready), 64'(!pat_d[i]));
      chk("cont_mem_en", 64'(mem_en),       64'h1);
      if (i > 0) begin
        if (pat_d[i-1]) chk("cont_d_rsp", d_rsp_data, init_word(61'h40));
        else            chk("cont_if_rsp", if_rsp_data, init_word(61'h30));
      end
      cyc();
    end
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    cyc();
    cyc();

    // Backpressure on the data response
    d_rsp_ready  = 1'b0;
    d_req_valid  = 1'b1;
    d_req_addr   = 61'h50;
    if_req_valid = 1'b1;
    if_req_addr  = 61'h60;
    #1;
    chk("bp_d_gnt",   64'(d_req_ready),  64'h1);
    chk("bp_if_wait0", 64'(if_req_ready), 64'h0);
    cyc();
    d_req_addr = 61'h51;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_d_held",  64'(d_req_ready),  64'h0);
      chk("bp_if_gnt",  64'(if_req_ready), 64'h1);
      chk("bp_d_valid", 64'(d_rsp_valid),  64'h1);
      chk("bp_d_data",  d_rsp_data,        init_word(61'h50));
      cyc();
    end
    d_rsp_ready = 1'b1;
    #1;
    chk("bp_regrant",  64'(d_req_ready),  64'h1);
    chk("bp_if_wait",  64'(if_req_ready), 64'h0);
    chk("bp_deliver",  d_rsp_data,        init_word(61'h50));
    cyc();
    d_req_valid  = 1'b0;
    if_req_valid = 1'b0;
    #1;
    chk("bp_next_valid", 64'(d_rsp_valid), 64'h1);
    chk("bp_next_data",  d_rsp_data,       init_word(61'h51));
    cyc();
    cyc();

    // Store then load to the same address
    d_req_valid = 1'b1;
    d_req_we    = 1'b1;
    d_req_addr  = 61'h20;
    d_req_wdata = 64'h1122_3344_5566_7788;
    #1;
    chk("st_gnt",   64'(d_req_ready), 64'h1);
    chk("st_we",    64'(mem_we),      64'h1);
    chk("st_addr",  64'(mem_addr),    64'h20);
    chk("st_wdata", mem_wdata,        64'h1122_3344_5566_7788);
    cyc();
    d_req_we    = 1'b0;
    d_req_wdata = 64'h0;
    #1;
    chk("st_ack_valid", 64'(d_rsp_valid), 64'h1);
    chk("st_ack_data",  d_rsp_data,       64'h0);
    chk("ld_gnt",       64'(d_req_ready), 64'h1);
    chk("ld_we",        64'(mem_we),      64'h0);
    cyc();
    d_req_valid = 1'b0;
    #1;
    chk("ld_valid", 64'(d_rsp_valid), 64'h1);
    chk("ld_data",  d_rsp_data,       64'h1122_3344_5566_7788);
    cyc();
    cyc();

    // Reset in the cycle after a fetch grant
    if_req_valid = 1'b1;
    if_req_addr  = 61'h10;
    #1;
    chk("mid_gnt", 64'(if_req_ready), 64'h1);
    cyc();
    if_req_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    chk("mid_no_rsp", 64'(if_rsp_valid), 64'h0);
    chk("mid_data",   if_rsp_data,       64'h0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("mid_hold", 64'(if_rsp_valid), 64'h0);
    end
    rst_n = 1'b1;
    #1;
    chk("mid_rel_if", 64'(if_rsp_valid), 64'h0);
    chk("mid_rel_d",  64'(d_rsp_valid),  64'h0);
    if_req_addr  = 61'h30;
    d_req_addr   = 61'h40;
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("post_d_gnt",  64'(d_req_ready),  64'(pat_d[i]));
      chk("post_if_gnt", 64'(if_req_ready), 64'(!pat_d[i]));
      cyc();
    end
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
